// File: rtl/fifo_burst_reader.sv
// Drains a 1-8 word burst from the upstream FIFO and forwards it on a valid/ready
// stream through a 2-entry skid buffer, accumulating a wrapping 32-bit sum.
module fifo_burst_reader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  burst_len,
  output logic        rd_en,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_empty,
  input  logic        rd_ack,
  input  logic        rd_err,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  issued_q, issued_d;
  logic [3:0]  received_q, received_d;
  logic [31:0] sum_q, sum_d;
  logic        err_q, err_d;
  logic        pending_q, pending_d;
  logic [31:0] buf_q [2];
  logic [31:0] buf_d [2];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;

  logic        pop_s;
  logic        push_s;
  logic        room_s;
  logic        rd_en_s;
  logic [2:0]  inflight_s;

  // Read gating: a word already requested still needs a buffer slot when its ack lands.
  always_comb begin
    pop_s      = (count_q != 2'd0) & out_ready;
    push_s     = rd_ack & (state_q != IDLE);
    inflight_s = {2'b00, pending_q} + {1'b0, count_q};
    room_s     = inflight_s < (3'd2 + {2'b00, pop_s});
    rd_en_s    = (state_q == RUN) & ~fifo_empty & (issued_q < len_q) & room_s & ~rd_err;
  end

  // Next-state, counters, accumulator and buffer bookkeeping.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    received_d = received_q;
    sum_d      = sum_q;
    err_d      = err_q;
    head_d     = head_q;
    tail_d     = tail_q;
    buf_d[0]   = buf_q[0];
    buf_d[1]   = buf_q[1];
    pending_d  = rd_en_s;
    count_d    = count_q + {1'b0, push_s} - {1'b0, pop_s};

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = ((burst_len == 4'd0) || (burst_len > 4'd8)) ? 4'd8 : burst_len;
          issued_d   = 4'd0;
          received_d = 4'd0;
          sum_d      = 32'd0;
          err_d      = 1'b0;
          state_d    = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (rd_err || (received_q == len_q)) begin
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if ((count_q == 2'd0) && !pending_q) begin
          state_d = DONE;
        end else begin
          state_d = FLUSH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rd_en_s) begin
      issued_d = issued_q + 4'd1;
    end else begin
      issued_d = issued_d;
    end

    if (push_s) begin
      buf_d[tail_q] = fifo_dout;
      tail_d        = ~tail_q;
      sum_d         = sum_q + fifo_dout;
      received_d    = received_q + 4'd1;
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      head_d = ~head_q;
    end else begin
      head_d = head_q;
    end

    if (rd_err && (state_q != IDLE)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q    <= IDLE;
      len_q      <= 4'd0;
      issued_q   <= 4'd0;
      received_q <= 4'd0;
      sum_q      <= 32'd0;
      err_q      <= 1'b0;
      pending_q  <= 1'b0;
      buf_q[0]   <= 32'd0;
      buf_q[1]   <= 32'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      pending_q  <= pending_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Output drive; data reads as zero while the buffer is empty.
  always_comb begin
    rd_en     = rd_en_s;
    out_valid = (count_q != 2'd0);
    out_data  = (count_q != 2'd0) ? buf_q[head_q] : 32'd0;
    sum       = sum_q;
    busy      = (state_q == RUN) || (state_q == FLUSH);
    done      = (state_q == DONE);
    err       = err_q;
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural 8-deep FIFO (1-cycle ack).
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  burst_len = 4'd0;
  logic        rd_en;
  logic [31:0] fifo_dout = 32'd0;
  logic        fifo_empty;
  logic        rd_ack = 1'b0;
  logic        rd_err = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        busy;
  logic        done;
  logic        err;

  // Behavioural upstream FIFO.
  logic [31:0] fmem [8];
  logic [2:0]  fwp = 3'd0;
  logic [2:0]  frp = 3'd0;
  logic [3:0]  fcnt = 4'd0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        fclr = 1'b0;
  logic        f_rd, f_wr;

  assign fifo_empty = (fcnt == 4'd0);
  assign f_rd = rd_en && (fcnt != 4'd0);
  assign f_wr = wr_en && (fcnt != 4'd8);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fclr) begin
      frp    <= fwp;
      fcnt   <= 4'd0;
      rd_ack <= 1'b0;
    end else begin
      if (f_wr) begin
        fmem[fwp] <= wr_data;
        fwp       <= fwp + 3'd1;
      end
      if (f_rd) begin
        fifo_dout <= fmem[frp];
        frp       <= frp + 3'd1;
      end
      rd_ack <= f_rd;
      fcnt   <= fcnt + {3'b000, f_wr} - {3'b000, f_rd};
    end
  end

  fifo_burst_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .burst_len(burst_len),
    .rd_en(rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .rd_ack(rd_ack), .rd_err(rd_err), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .sum(sum), .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] got [$];
  int rd_cnt, done_cnt;
  logic        s_rd_en, s_valid, s_done, s_busy, s_err;
  logic [31:0] s_data, s_sum;

  typedef struct {
    logic [3:0]  len;
    int          npre;
    logic [31:0] base;
    logic [31:0] step;
    logic [15:0] pat;
    int          exp_cnt;
    logic [31:0] exp_sum;
    int          exp_left;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_rd_en = rd_en; s_valid = out_valid; s_data = out_data;
    s_done = done; s_busy = busy; s_err = err; s_sum = sum;
    if (out_valid && out_ready) got.push_back(out_data);
    if (rd_en) rd_cnt++;
    if (done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    got.delete();
    rd_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic clear_fifo();
    fclr = 1'b1;
    tick();
    fclr = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    wr_en = 1'b1;
    wr_data = w;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] len);
    burst_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string nm);
    int n;
    n = 0;
    while (done_cnt == 0 && n < limit) begin
      tick();
      n++;
    end
    chk({nm, "_done"}, done_cnt, 32'd1);
  endtask

  initial begin
    logic [11:0] m_rd, m_val, m_done, m_busy;
    logic [31:0] w;

    vt[0] = '{4'd0,  8, 32'hFFFF_FFFF, 32'd0,         16'hFFFF, 8, 32'hFFFF_FFF8, 0};
    vt[1] = '{4'd3,  5, 32'd1,         32'd1,         16'hFFFF, 3, 32'd6,         2};
    vt[2] = '{4'd12, 8, 32'h10,        32'h10,        16'hAAAA, 8, 32'h240,       0};
    vt[3] = '{4'd1,  2, 32'hDEAD_BEEF, 32'd1,         16'h0F0F, 1, 32'hDEAD_BEEF, 1};
    vt[4] = '{4'd6,  6, 32'h8000_0000, 32'h4000_0000, 16'h1111, 6, 32'hC000_0000, 0};

    clr_mon();
    tick();
    tick();
    chk("rst_rd_en", {31'd0, s_rd_en}, 32'd0);
    chk("rst_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_data", s_data, 32'd0);
    chk("rst_sum", s_sum, 32'd0);
    chk("rst_busy", {31'd0, s_busy}, 32'd0);
    chk("rst_done", {31'd0, s_done}, 32'd0);
    chk("rst_err", {31'd0, s_err}, 32'd0);
    reset_n = 1'b0;
    tick();

    // Basic burst of 4 with cycle-exact timing.
    for (int k = 1; k <= 4; k++) push_word(32'(k));
    out_ready = 1'b1;
    pulse_start(4'd4);
    clr_mon();
    for (int i = 0; i < 12; i++) begin
      tick();
      m_rd[i] = s_rd_en; m_val[i] = s_valid; m_done[i] = s_done; m_busy[i] = s_busy;
      if (i >= 2 && i <= 5) chk("t1_data", s_data, 32'(i - 1));
    end
    chk("t1_rd_en_mask", {20'd0, m_rd}, 32'h00F);
    chk("t1_valid_mask", {20'd0, m_val}, 32'h03C);
    chk("t1_done_mask", {20'd0, m_done}, 32'h080);
    chk("t1_busy_mask", {20'd0, m_busy}, 32'h07F);
    chk("t1_sum", s_sum, 32'd10);
    chk("t1_err", {31'd0, s_err}, 32'd0);
    chk("t1_nwords", got.size(), 32'd4);

    // Backpressure: burst of 6 with consumer stalled.
    clear_fifo();
    for (int k = 0; k < 6; k++) push_word(32'd101 + 32'(k));
    out_ready = 1'b0;
    pulse_start(4'd6);
    clr_mon();
    for (int i = 0; i < 10; i++) tick();
    chk("bp_reads", rd_cnt, 32'd2);
    chk("bp_valid", {31'd0, s_valid}, 32'd1);
    chk("bp_head", s_data, 32'd101);
    out_ready = 1'b1;
    wait_done(100, "bp");
    chk("bp_nwords", got.size(), 32'd6);
    for (int k = 0; k < got.size(); k++) chk("bp_word", got[k], 32'd101 + 32'(k));

    // Empty FIFO mid-burst stalls until more words arrive.
    clear_fifo();
    push_word(32'd1);
    push_word(32'd2);
    pulse_start(4'd5);
    clr_mon();
    for (int i = 0; i < 20; i++) tick();
    chk("st_busy", {31'd0, s_busy}, 32'd1);
    chk("st_no_done", done_cnt, 32'd0);
    chk("st_partial", got.size(), 32'd2);
    for (int k = 3; k <= 5; k++) push_word(32'(k));
    wait_done(100, "st");
    chk("st_nwords", got.size(), 32'd5);
    chk("st_sum", s_sum, 32'd15);

    // Start while busy ignored; injected read error forces FLUSH -> DONE.
    clear_fifo();
    for (int k = 0; k < 4; k++) push_word(32'h11 + 32'(k));
    pulse_start(4'd8);
    clr_mon();
    pulse_start(4'd1);
    for (int i = 0; i < 8; i++) tick();
    chk("er_pre_words", got.size(), 32'd4);
    chk("er_pre_busy", {31'd0, s_busy}, 32'd1);
    chk("er_pre_done", done_cnt, 32'd0);
    clr_mon();
    rd_err = 1'b1;
    tick();
    rd_err = 1'b0;
    tick();
    chk("er_err", {31'd0, s_err}, 32'd1);
    push_word(32'h77);
    push_word(32'h78);
    wait_done(50, "er");
    for (int i = 0; i < 3; i++) tick();
    chk("er_no_rd", rd_cnt, 32'd0);
    chk("er_sticky", {31'd0, s_err}, 32'd1);
    chk("er_left", {28'd0, fcnt}, 32'd2);

    // Table of bursts with varying length, data and consumer patterns.
    for (int v = 0; v < 5; v++) begin
      int cyc;
      clear_fifo();
      for (int k = 0; k < vt[v].npre; k++) push_word(vt[v].base + vt[v].step * 32'(k));
      out_ready = vt[v].pat[0];
      pulse_start(vt[v].len);
      clr_mon();
      cyc = 1;
      while (done_cnt == 0 && cyc < 300) begin
        out_ready = vt[v].pat[cyc % 16];
        tick();
        cyc++;
      end
      chk("tv_done", done_cnt, 32'd1);
      chk("tv_nwords", got.size(), 32'(vt[v].exp_cnt));
      for (int k = 0; k < got.size(); k++) begin
        w = vt[v].base + vt[v].step * 32'(k);
        chk("tv_word", got[k], w);
      end
      chk("tv_sum", s_sum, vt[v].exp_sum);
      chk("tv_err", {31'd0, s_err}, 32'd0);
      chk("tv_left", {28'd0, fcnt}, 32'(vt[v].exp_left));
    end

    // Asynchronous reset mid-burst, then a clean burst.
    clear_fifo();
    for (int k = 0; k < 8; k++) push_word(32'hA0 + 32'(k));
    out_ready = 1'b0;
    pulse_start(4'd8);
    for (int i = 0; i < 3; i++) tick();
    #2;
    reset_n = 1'b1;
    #1;
    chk("ar_rd_en", {31'd0, rd_en}, 32'd0);
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_data", out_data, 32'd0);
    chk("ar_sum", sum, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk("ar_err", {31'd0, err}, 32'd0);
    tick();
    reset_n = 1'b0;
    clear_fifo();
    push_word(32'd7);
    push_word(32'd9);
    out_ready = 1'b1;
    pulse_start(4'd2);
    clr_mon();
    wait_done(50, "ar");
    chk("ar_nwords", got.size(), 32'd2);
    if (got.size() == 2) begin
      chk("ar_w0", got[0], 32'd7);
      chk("ar_w1", got[1], 32'd9);
    end
    chk("ar_sum2", s_sum, 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Downstream consumer of the 32-bit, 8-deep `fifo`. On a `start` pulse it drains a burst of 1–8 words from the FIFO through its `rd_en`/`rd_ack` handshake and forwards them on a valid/ready output stream. A 2-entry output buffer absorbs backpressure. It also produces a 32-bit running sum of the burst and a one-cycle `done` pulse.

## Interface
No parameters; widths are fixed to match `fifo`.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, **active-high** reset. Name kept for codebase consistency; the polarity is high.
- `start` in 1: begin burst; sampled only in IDLE.
- `burst_len` in 4: words in burst; 1–8 literal, 0 means 8, values 9–15 saturate to 8.
- `rd_en` out 1: FIFO read request (to `fifo.rd_en`).
- `fifo_dout` in 32: from `fifo.dout`.
- `fifo_empty` in 1: from `fifo.empty`.
- `rd_ack` in 1: from `fifo.rd_ack`.
- `rd_err` in 1: from `fifo.rd_err`.
- `out_valid` out 1: `out_data` holds a valid word.
- `out_data` out 32: head of output buffer.
- `out_ready` in 1: consumer accepts the word when `out_valid & out_ready`.
- `sum` out 32: mod-2^32 sum of words received this burst.
- `busy` out 1: high in RUN and FLUSH.
- `done` out 1: one-cycle pulse at burst end.
- `err` out 1: sticky until next accepted `start` or reset.

## Operation
- States: IDLE, RUN, FLUSH, DONE. Encoding is free.
- **IDLE**
  - On `start=1`: latch len (0 or >8 → 8), clear `issued`, `received`, `sum` and `err`; go to RUN.
  - `start` is ignored in every other state.
- **RUN**
  - `rd_en = !fifo_empty & (issued < len) & (pending + occupancy − pop < 2)`.
  - `pending`: an `rd_en` was issued last cycle and is not yet acked (0 or 1).
  - `pop`: `out_valid & out_ready` this cycle.
  - Each `rd_en`: `issued++`.
- **Ack** (`rd_ack=1`, any non-IDLE state): write `fifo_dout` into the buffer tail, `sum <= sum + fifo_dout` (carry dropped), `received++`.
- **Error** (`rd_err=1`): set `err`, stop issuing `rd_en`, go to FLUSH.
- RUN → FLUSH when `received == len` (evaluated on the registered count).
- **FLUSH**: no `rd_en`; go to DONE when the buffer is empty (occupancy 0, no pending).
- **DONE**: `done=1` for exactly one cycle, then IDLE. `sum` holds until the next `start`.
- **Buffer**: 2-entry circular (1-bit head/tail plus count).
  - Push and pop in the same cycle are both allowed.
  - Never overflows, because the `rd_en` gating accounts for in-flight acks.
  - `out_data` shows the head entry; it is 0 when empty.

## Timing
- Reset values: `rd_en=0`, `out_valid=0`, `out_data=0`, `sum=0`, `busy=0`, `done=0`, `err=0`, state IDLE, counters 0, buffer empty.
- `start` at edge t → RUN at t+1; first `rd_en` can assert in cycle t+1.
- FIFO latency: `rd_en` high in cycle c → `rd_ack` and `fifo_dout` valid in cycle c+1. Capture on the c+1→c+2 edge; `out_valid` is high in cycle c+2.
- Throughput: with `out_ready=1` and the FIFO non-empty, one word per cycle (`rd_en` continuous).
- With `out_ready=0`, `rd_en` drops once `pending + occupancy = 2` and resumes the cycle after a pop.
- An empty FIFO mid-burst stalls RUN indefinitely. No timeout.
- `busy` falls and `done` rises in the same cycle (DONE).
- An async reset mid-burst returns everything to reset values immediately. FIFO words already popped are lost.

## Test plan
- FIFO preloaded with 1,2,3,4, `burst_len=4`, `out_ready=1`, `start` pulse:
  - `rd_en` is high for 4 consecutive cycles starting 1 cycle after `start`.
  - `out_data` is 1,2,3,4 on consecutive cycles.
  - `sum=10`, then `done` pulses; `err=0`.
- `burst_len=0` with 8 words of 0xFFFFFFFF: 8 words out, `sum=0xFFFFFFF8` (wrap), FIFO empty afterwards.
- `out_ready=0` during a burst of 6: `rd_en` stops after 2 reads and `out_valid` stays high with word 1. After `out_ready` rises, all 6 words arrive in order with none dropped.
- FIFO holds 2 words with `burst_len=5`:
  - The block stalls in RUN (`busy=1`, no `done`).
  - Writing 3 more words into the FIFO completes the burst; `done` pulses.
- Assert `reset_n` mid-burst:
  - All outputs go to reset values asynchronously.
  - A new `start` afterwards runs a clean burst.
- `start` pulsed while busy is ignored. `rd_err` forced high for one cycle: `err=1`, `rd_en` stops, and the block goes FLUSH → DONE.
